fifo_nibble_packer: RTL
=======================

FIFO_NIBBLE_PACKER -- requirements
Module: fifo_nibble_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of one FIFO entry (nibble) SHALL be set by it.
REQ-002 Parameter TIMEOUT, default 8, number of idle cycles waiting for a second nibble before a partial flush SHALL be set by it; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-006 fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en is asserted.
REQ-008 out_data  output  2*DATA_WIDTH  packed word, first-read nibble in the low half.
REQ-009 out_valid  output  1  out_data holds a packed word.
REQ-010 out_ready  input  1  downstream accepts the word when high together with out_valid.
REQ-011 out_partial  output  1  high half of out_data is zero padding from a timeout flush.
REQ-012 busy  output  1  packer holds or awaits any nibble.

Function
REQ-013 FSM states SHALL be S_LO (awaiting first nibble), S_HI (awaiting second nibble), S_OUT (presenting word).
REQ-014 A single-bit pend register SHALL equal fifo_rd_en of the previous cycle; at most one read SHALL be outstanding.
REQ-015 fifo_rd_en SHALL be combinational: 1 iff state is S_LO or S_HI, fifo_empty=0, pend=0, rst=0.
REQ-016 In S_LO with pend=1, fifo_data SHALL be stored as lo, the idle timer cleared, and the next state SHALL be S_HI.
REQ-017 In S_HI with pend=1, fifo_data SHALL be stored as hi, out_partial cleared, and the next state SHALL be S_OUT.
REQ-018 In S_HI the idle timer SHALL increment each cycle with pend=0 and fifo_rd_en=0 and clear on any cycle with fifo_rd_en=1.
REQ-019 When the timer reaches TIMEOUT in S_HI, hi SHALL be set to zero, out_partial set to 1, next state S_OUT; if fifo_rd_en=1 in that cycle the read SHALL win and no flush occurs.
REQ-020 out_valid SHALL be 1 exactly in S_OUT; out_data and out_partial SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 In S_OUT with out_ready=1 the next state SHALL be S_LO; no FIFO read SHALL be issued in S_OUT.
REQ-022 Latency: with a non-empty FIFO holding two nibbles and out_ready=1, out_valid SHALL assert 4 cycles after the first fifo_rd_en pulse (reads at cycles 0 and 2).
REQ-023 Sustained throughput SHALL be one word per 5 cycles with continuous data and out_ready=1.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 busy SHALL equal (state != S_LO) or pend.
REQ-026 out_data SHALL be {hi, lo}, no arithmetic; timer width SHALL be 8 bits, no wrap (saturates via REQ-019).

Reset
REQ-027 While rst=1: state S_LO, pend 0, lo and hi 0, timer 0, out_valid 0, out_partial 0, fifo_rd_en 0, busy 0.
REQ-028 Reset mid-operation SHALL discard any captured or pending nibble; FIFO data returned the cycle after reset deassertion for a pre-reset read SHALL be ignored.
REQ-029 The first fifo_rd_en SHALL occur no earlier than the first cycle with rst=0.

Structure
REQ-030 A shared package fifo_pack_pkg SHALL hold the state enumeration, default DATA_WIDTH (4) and default TIMEOUT (8).
REQ-031 The idle timer SHALL be one sub-module, pack_idle_timer (inputs clear, inc; output expired), instantiated once.

Verification
REQ-032 FIFO preloaded 0x3 then 0xA, out_ready=1 -> rd_en at cycles 0 and 2, out_valid at cycle 4, out_data=0xA3, out_partial=0.
REQ-033 FIFO holds single nibble 0x5, TIMEOUT=8 -> after 8 idle cycles in S_HI out_data=0x05, out_partial=1.
REQ-034 Word 0x7C ready, out_ready=0 for 10 cycles -> out_data held at 0x7C, no rd_en; out_ready=1 -> accepted, back to S_LO.
REQ-035 Second nibble 0x9 appears in the cycle timer reaches TIMEOUT -> read wins, out_data=0x9L, out_partial=0.
REQ-036 rst=1 for one cycle while pend=1 -> all outputs zero, returned nibble dropped, next word packs only post-reset nibbles.
REQ-037 Stream 0x0..0xF continuously, out_ready=1 -> words 0x10,0x32,...,0xFE, one every 5 cycles, no loss or duplication.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// Shared definitions for the FIFO nibble packer: FSM state encoding and
// default geometry.
package fifo_pack_pkg;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } pack_state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_TIMEOUT    = 8;
    localparam int TIMER_W        = 8;

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// Upstream FIFO read port plus downstream packed-word port of the nibble
// packer. master = packer side, slave = FIFO/consumer side.
interface fifo_nibble_packer_if #(
    parameter int DATA_WIDTH = fifo_pack_pkg::DEF_DATA_WIDTH
);
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic [DATA_WIDTH-1:0]     fifo_data;
    logic [2*DATA_WIDTH-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_partial;
    logic                      busy;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, out_partial, busy
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_partial, busy
    );
endinterface

// File: rtl/pack_idle_timer.sv
// Saturating idle counter: counts idle cycles while waiting for the second
// nibble and flags when TIMEOUT of them have elapsed.
module pack_idle_timer
    import fifo_pack_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] count_q;

    // Holding at LIMIT keeps the counter from ever wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc && (count_q < LIMIT)) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign expired = (count_q >= LIMIT);
endmodule

// File: rtl/fifo_nibble_packer.sv
// Reads nibbles from an upstream FIFO and packs pairs into words, first
// nibble in the low half; a lone nibble is flushed zero-padded after TIMEOUT.
module fifo_nibble_packer
    import fifo_pack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_nibble_packer_if.master  bus
);
    pack_state_t           state_q, state_d;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  partial_q, partial_d;
    logic                  rd_en;
    logic                  t_clear, t_inc, t_expired;

    // Only one read in flight: the returned nibble must land before the next.
    assign rd_en = ((state_q == S_LO) || (state_q == S_HI)) &&
                   !bus.fifo_empty && !pend_q && !rst;

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (t_clear),
        .inc     (t_inc),
        .expired (t_expired)
    );

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        partial_d = partial_q;
        t_clear   = rd_en;
        t_inc     = 1'b0;
        case (state_q)
            S_LO: begin
                if (pend_q) begin
                    lo_d    = bus.fifo_data;
                    t_clear = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (pend_q) begin
                    hi_d      = bus.fifo_data;
                    partial_d = 1'b0;
                    state_d   = S_OUT;
                end else if (!rd_en) begin
                    // A read issued in the expiry cycle takes precedence over the flush.
                    if (t_expired) begin
                        hi_d      = '0;
                        partial_d = 1'b1;
                        state_d   = S_OUT;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LO;
            pend_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= rd_en;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            partial_q <= partial_d;
        end
    end

    // Outputs are forced low during the reset cycle itself, not just after it.
    assign bus.fifo_rd_en  = rd_en;
    assign bus.out_valid   = (state_q == S_OUT) && !rst;
    assign bus.out_partial = partial_q && !rst;
    assign bus.out_data    = rst ? '0 : {hi_q, lo_q};
    assign bus.busy        = ((state_q != S_LO) || pend_q) && !rst;
endmodule
